// File: rtl/reg_file_param.sv
// rtl/reg_file_param.sv - parameterised register file with bypass and sequenced clear
// Two combinational read ports, one synchronous write port, DEPTH-cycle clear sweep.
module reg_file_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Reg_Write_i,
  input  logic [ADDR_W-1:0] Write_Register_i,
  input  logic [DATA_W-1:0] Write_Data_i,
  input  logic [ADDR_W-1:0] Read_Register_1_i,
  input  logic [ADDR_W-1:0] Read_Register_2_i,
  input  logic              Clear_i,
  output logic [DATA_W-1:0] Read_Data_1_o,
  output logic [DATA_W-1:0] Read_Data_2_o,
  output logic              Busy_o,
  output logic              Write_Drop_o
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              drop_q, drop_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic wr_is_zero_reg;
  logic we_eff;

  assign wr_is_zero_reg = (ZERO_REG != 0) && (Write_Register_i == '0);
  assign we_eff = Reg_Write_i && (state_q == ST_IDLE) && !reset && !wr_is_zero_reg;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drop_d  = 1'b0;
    if (state_q == ST_IDLE) begin
      cnt_d = '0;
      if (Clear_i) state_d = ST_CLEAR;
    end else begin
      drop_d = Reg_Write_i && !wr_is_zero_reg;
      cnt_d  = cnt_q + ADDR_W'(1);
      if (cnt_q == ADDR_W'(DEPTH - 1)) state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drop_q  <= drop_d;
    end
  end

  // The sweep owns the array while clearing; writes only land in IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (state_q == ST_CLEAR) begin
      mem_q[cnt_q] <= '0;
    end else if (we_eff) begin
      mem_q[Write_Register_i] <= Write_Data_i;
    end
  end

  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] ra);
    logic [DATA_W-1:0] rd;
    rd = mem_q[ra];
    if ((BYPASS != 0) && we_eff && (Write_Register_i == ra)) rd = Write_Data_i;
    if ((ZERO_REG != 0) && (ra == '0)) rd = '0;
    return rd;
  endfunction

  assign Read_Data_1_o = read_port(Read_Register_1_i);
  assign Read_Data_2_o = read_port(Read_Register_2_i);
  assign Busy_o        = (state_q == ST_CLEAR);
  assign Write_Drop_o  = drop_q;

endmodule

// File: tb/tb_reg_file_param.sv
// tb/tb_reg_file_param.sv - directed-vector bench for reg_file_param
// Instance a: 32x32, zero register, bypass. Instance b: 16x8, no zero register, no bypass.
module tb_reg_file_param;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        rw, clr;
  logic [4:0]  wa, ra1, ra2;
  logic [31:0] wd, rd1, rd2;
  logic        busy, drop;

  logic        rw_b, clr_b;
  logic [2:0]  wa_b, ra1_b, ra2_b;
  logic [15:0] wd_b, rd1_b, rd2_b;
  logic        busy_b, drop_b;

  int n_vec = 0;
  int n_err = 0;
  int n;

  reg_file_param u_dut_a (
    .clk(clk), .reset(reset),
    .Reg_Write_i(rw), .Write_Register_i(wa), .Write_Data_i(wd),
    .Read_Register_1_i(ra1), .Read_Register_2_i(ra2), .Clear_i(clr),
    .Read_Data_1_o(rd1), .Read_Data_2_o(rd2), .Busy_o(busy), .Write_Drop_o(drop)
  );

  reg_file_param #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(0), .BYPASS(0)) u_dut_b (
    .clk(clk), .reset(reset),
    .Reg_Write_i(rw_b), .Write_Register_i(wa_b), .Write_Data_i(wd_b),
    .Read_Register_1_i(ra1_b), .Read_Register_2_i(ra2_b), .Clear_i(clr_b),
    .Read_Data_1_o(rd1_b), .Read_Data_2_o(rd2_b), .Busy_o(busy_b), .Write_Drop_o(drop_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    rw = 0; clr = 0; wa = 0; wd = 0; ra1 = 0; ra2 = 0;
    rw_b = 0; clr_b = 0; wa_b = 0; wd_b = 0; ra1_b = 0; ra2_b = 0;
    tick; tick;
    reset = 1'b0;
    ra1 = 5'd3; ra2 = 5'd31; #1;
    check("rst_busy", busy, 0);
    check("rst_drop", drop, 0);
    check("rst_rd1", rd1, 0);
    check("rst_rd2", rd2, 0);
    check("rst_busy_b", busy_b, 0);

    rw = 1; wa = 5'd5; wd = 32'hDEADBEEF; tick;
    wa = 5'd31; wd = 32'h12345678; tick;
    rw = 0; ra1 = 5'd5; ra2 = 5'd31; #1;
    check("wr_r5", rd1, 32'hDEADBEEF);
    check("wr_r31", rd2, 32'h12345678);
    ra1 = 5'd12; #1;
    check("unwritten_r12", rd1, 0);

    rw = 1; wa = 5'd0; wd = 32'hFFFFFFFF; ra1 = 5'd0; ra2 = 5'd0; #1;
    check("r0_nobypass_p1", rd1, 0);
    check("r0_nobypass_p2", rd2, 0);
    tick;
    rw = 0; #1;
    check("r0_p1", rd1, 0);
    check("r0_p2", rd2, 0);
    check("r0_nodrop", drop, 0);

    rw_b = 1; wa_b = 3'd0; wd_b = 16'hFFFF; ra1_b = 3'd0; #1;
    check("b_r0_same_cycle", rd1_b, 0);
    tick;
    rw_b = 0; #1;
    check("b_r0_stored", rd1_b, 32'h0000FFFF);

    rw = 1; wa = 5'd7; wd = 32'h1; tick;
    wd = 32'hA5A5A5A5; ra1 = 5'd7; ra2 = 5'd7; #1;
    check("bypass_p1", rd1, 32'hA5A5A5A5);
    check("bypass_p2", rd2, 32'hA5A5A5A5);
    tick;
    rw = 0; #1;
    check("bypass_stored", rd1, 32'hA5A5A5A5);

    rw_b = 1; wa_b = 3'd7; wd_b = 16'h1; tick;
    wd_b = 16'hA5A5; ra1_b = 3'd7; ra2_b = 3'd7; #1;
    check("b_nobypass", rd1_b, 32'h1);
    tick;
    rw_b = 0; #1;
    check("b_next_cycle", rd2_b, 32'hA5A5);

    for (int i = 0; i < 32; i++) begin
      rw = 1; wa = 5'(i); wd = i; tick;
    end
    rw = 0; ra1 = 5'd10; ra2 = 5'd20; #1;
    check("fill_r10", rd1, 10);
    check("fill_r20", rd2, 20);

    // Clear_i sampled at this edge; busy cycle n=1 starts right after.
    clr = 1; tick;
    clr = 0;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      rw = 0; clr = 0;
      if (n == 11) begin
        ra1 = 5'd9; ra2 = 5'd10; #1;
        check("clr_r9", rd1, 0);
        check("clr_r10", rd2, 10);
      end
      if (n == 15) begin
        rw = 1; wa = 5'd20; wd = 32'h55; ra1 = 5'd20; #1;
        check("clr_wr_nobypass", rd1, 20);
      end
      if (n == 16) check("drop_pulse", drop, 1);
      if (n == 17) check("drop_end", drop, 0);
      if (n == 18) clr = 1;
      tick;
    end
    rw = 0; clr = 0;
    check("busy_len", n, 32);
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i); #1;
      check($sformatf("after_clr_r%0d", i), rd1, 0);
    end

    rw = 1; wa = 5'd3; wd = 32'h33; tick;
    wa = 5'd30; wd = 32'h777; tick;
    rw = 0; clr = 1; tick;
    clr = 0;
    tick; tick; tick; tick;
    reset = 1; tick;
    reset = 0; ra1 = 5'd3; ra2 = 5'd30; #1;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_r3", rd1, 0);
    check("rst_mid_r30", rd2, 0);
    rw = 1; wa = 5'd4; wd = 32'hCAFE; tick;
    rw = 0; ra1 = 5'd4; #1;
    check("post_rst_wr", rd1, 32'hCAFE);

    clr_b = 1; tick;
    clr_b = 0;
    n = 0;
    while (busy_b === 1'b1 && n < 100) begin
      n++;
      tick;
    end
    check("b_busy_len", n, 8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
